// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix multiplier.
// Holds the job FSM encoding and latency/counter sizing functions.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_DONE
  } mm_state_t;

  function automatic int mm_latency(input int n);
    return 3 * n - 1;
  endfunction

  function automatic int mm_cnt_w(input int n);
    return $clog2(3 * n - 1);
  endfunction

endpackage

// File: rtl/systolic_pe_acc.sv
// Output-stationary PE: registered A/B pass-through plus MAC accumulator.
// SYSTOLIC_SAT_EN selects sticky saturation instead of modulo wrap.
module systolic_pe_acc
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [ACC_W-1:0]  o_acc
);

  localparam logic [ACC_W-1:0] HI_MASK =
    ~ACC_W'({(2*DATA_W){1'b1}});

  logic [2*DATA_W-1:0] w_a_w;
  logic [2*DATA_W-1:0] w_b_w;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_prod_ext;
  logic [ACC_W-1:0]    w_next;
  logic [ACC_W-1:0]    r_acc;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;

  // Low 2*DATA_W product bits are exact once operands are pre-extended
  assign w_a_w = {{DATA_W{i_signed & i_a[DATA_W-1]}}, i_a};
  assign w_b_w = {{DATA_W{i_signed & i_b[DATA_W-1]}}, i_b};
  assign w_prod = w_a_w * w_b_w;
  assign w_prod_ext = ACC_W'(w_prod) |
    ((i_signed & w_prod[2*DATA_W-1]) ? HI_MASK : '0);

`ifdef SYSTOLIC_SAT_EN
  logic [ACC_W:0] w_sum_u;
  logic [ACC_W:0] w_sum_s;
  logic           w_ovf;
  logic           r_sat;

  assign w_sum_u = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_sum_s = {r_acc[ACC_W-1], r_acc} +
                   {w_prod_ext[ACC_W-1], w_prod_ext};

  always_comb begin
    w_next = w_sum_u[ACC_W-1:0];
    w_ovf  = 1'b0;
    if (i_signed) begin
      if (w_sum_s[ACC_W] != w_sum_s[ACC_W-1]) begin
        w_ovf  = 1'b1;
        w_next = w_sum_s[ACC_W] ?
          {1'b1, {(ACC_W-1){1'b0}}} :
          {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (w_sum_u[ACC_W]) begin
      w_ovf  = 1'b1;
      w_next = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_sat <= 1'b0;
    end else if (i_en && w_ovf) begin
      r_sat <= 1'b1;
    end
  end
`else
  logic r_sat;

  assign w_next = r_acc + w_prod_ext;
  assign r_sat  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_acc <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (i_en) begin
      r_a <= i_a;
      r_b <= i_b;
      if (!r_sat) begin
        r_acc <= w_next;
      end
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_matmul.sv
// NxN output-stationary systolic matrix multiplier, Y = A x B.
// Define SYSTOLIC_SAT_EN for saturating accumulation.
module systolic_matmul
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    signed_mode,
  input  logic [N*N*DATA_W-1:0]   matrix_A,
  input  logic [N*N*DATA_W-1:0]   matrix_B,
  output logic [N*N*ACC_W-1:0]    y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int CW = mm_cnt_w(N);
  localparam logic [CW-1:0] LAST_C =
    CW'(mm_latency(N) - 1);

  mm_state_t             r_state;
  mm_state_t             w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic                  r_mode;
  logic [N*N*DATA_W-1:0] r_a;
  logic [N*N*DATA_W-1:0] r_b;
  logic [N*N*ACC_W-1:0]  r_y;
  logic [N*N*ACC_W-1:0]  w_acc_flat;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_en;

  logic [DATA_W-1:0] w_a_el   [N][N];
  logic [DATA_W-1:0] w_b_el   [N][N];
  logic [DATA_W-1:0] w_a_pipe [N][N+1];
  logic [DATA_W-1:0] w_b_pipe [N+1][N];
  logic [ACC_W-1:0]  w_acc    [N][N];

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        busy = 1'b1;
        if (r_cnt == LAST_C) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt  <= '0;
        r_mode <= signed_mode;
        r_a    <= matrix_A;
        r_b    <= matrix_B;
      end else if (r_state == ST_COMPUTE && !w_capture) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_capture) begin
        r_y <= w_acc_flat;
      end
    end
  end

  assign w_en = (r_state == ST_COMPUTE);
  assign y    = r_y;

  // Skewed edge feed: row/col i sees element k = t - i, else zero
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_a_pipe[i][0] = '0;
      w_b_pipe[0][i] = '0;
      for (int k = 0; k < N; k++) begin
        if (int'(r_cnt) == i + k) begin
          w_a_pipe[i][0] = w_a_el[i][k];
          w_b_pipe[0][i] = w_b_el[k][i];
        end
      end
    end
  end

  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      localparam int K = gr * N + gc;

      assign w_a_el[gr][gc] =
        r_a[(N*N-K)*DATA_W-1 -: DATA_W];
      assign w_b_el[gr][gc] =
        r_b[(N*N-K)*DATA_W-1 -: DATA_W];
      assign w_acc_flat[(N*N-K)*ACC_W-1 -: ACC_W] =
        w_acc[gr][gc];

      systolic_pe_acc #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_accept),
        .i_en     (w_en),
        .i_signed (r_mode),
        .i_a      (w_a_pipe[gr][gc]),
        .i_b      (w_b_pipe[gr][gc]),
        .o_a      (w_a_pipe[gr][gc+1]),
        .o_b      (w_b_pipe[gr+1][gc]),
        .o_acc    (w_acc[gr][gc])
      );
    end
  end

endmodule
